// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised asynchronous serial receiver.
//
// Receives frames of the form start, DATA_BITS data bits sent LSB first, an
// optional parity bit and STOP_BITS stop bits. Each bit is decided by a
// 3-sample majority vote around the bit centre. The oversampling tick comes
// from a phase accumulator, so the long-run tick rate is exact. A completed
// frame is held behind a valid/ready handshake together with its error flags.
//
// Parameters:
//   CLOCK_RATE    system clock frequency, Hz
//   BAUD_RATE     line bit rate, bits/s
//   RX_OVERSAMPLE ticks per bit (even, >= 8)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY        0 none, 1 odd, 2 even
//   STOP_BITS     stop bits checked (1 or 2)
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   i_Rx_Data     serial line, idle high, asynchronous to clk
//   i_Rx_Ready    consumer takes the held frame when high with o_Rx_Valid
//   i_Err_Clr     one-cycle pulse clearing sticky o_Overrun
//   o_Rx_Byte     held data, bit 0 = first data bit on the line
//   o_Rx_Valid    held frame available
//   o_Parity_Err  parity mismatch on the held frame
//   o_Frame_Err   a stop bit of the held frame was sampled low
//   o_Break       the held frame is a break (everything sampled low)
//   o_Overrun     sticky: a completed frame was dropped
module uart_rx_param #(
  parameter int CLOCK_RATE    = 25000000,
  parameter int BAUD_RATE     = 115200,
  parameter int RX_OVERSAMPLE = 16,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_Rx_Data,
  input  logic                 i_Rx_Ready,
  input  logic                 i_Err_Clr,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Rx_Valid,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Overrun
);

  localparam int CW = $clog2(RX_OVERSAMPLE);
  localparam int M  = RX_OVERSAMPLE / 2;

  // Phase step per clk and the full-scale modulus. The tick threshold is
  // tested as acc >= CR - INC so the whole accumulator stays within 32 bits
  // (acc is always below CR).
  localparam logic [31:0] INC = 32'(BAUD_RATE * RX_OVERSAMPLE);
  localparam logic [31:0] CR  = 32'(CLOCK_RATE);
  localparam logic [31:0] GAP = CR - INC;

  localparam logic HAS_PAR = (PARITY != 0);
  localparam logic ODD_PAR = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_BRK_WAIT
  } state_t;

  state_t                state;

  logic                  rx_meta, rx_sync, rx_prev;
  logic [31:0]           acc;
  logic [CW-1:0]         cnt;
  logic                  s0, s1;

  logic                  tick;
  logic                  start_edge;
  logic                  maj;
  logic                  decide;
  logic                  last_stop;
  logic                  frm_brk;
  logic                  frm_fe;

  logic [3:0]            bit_idx;
  logic                  stop_idx;
  logic [DATA_BITS-1:0]  shreg;
  logic                  zero_acc;   // every bit so far sampled low
  logic                  fe_acc;     // an earlier stop bit sampled low
  logic                  pe_acc;
  logic                  hi_flag;    // line high since the previous tick

  assign tick       = (acc >= GAP);
  assign start_edge = (state == ST_IDLE) & rx_prev & ~rx_sync;
  assign maj        = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
  assign decide     = tick & (cnt == CW'(M + 1));
  assign last_stop  = decide & (state == ST_STOP) & (stop_idx == 1'(STOP_BITS - 1));
  // Break and frame error include the stop bit being decided right now.
  assign frm_brk    = zero_acc & ~maj;
  assign frm_fe     = fe_acc | ~maj;

  // Synchroniser, edge history, tick generator, per-bit counter and the
  // two early majority samples. The counter free-runs across bit boundaries,
  // so the FSM only acts on the decision tick of each bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      acc     <= '0;
      cnt     <= '0;
      s0      <= 1'b0;
      s1      <= 1'b0;
    end else begin
      rx_meta <= i_Rx_Data;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (start_edge) begin
        // Re-phase the bit clock on the start edge.
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= tick ? (acc - GAP) : (acc + INC);
        if (tick) begin
          cnt <= (cnt == CW'(RX_OVERSAMPLE - 1)) ? '0 : cnt + 1'b1;
          if (cnt == CW'(M - 1)) s0 <= rx_sync;
          if (cnt == CW'(M))     s1 <= rx_sync;
        end
      end
    end
  end

  // Frame FSM plus the registered output/handshake logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      shreg        <= '0;
      zero_acc     <= 1'b0;
      fe_acc       <= 1'b0;
      pe_acc       <= 1'b0;
      hi_flag      <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Rx_Valid   <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
      o_Overrun    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_edge) state <= ST_START;
        end

        ST_START: begin
          if (decide) begin
            if (maj) begin
              state <= ST_IDLE;        // glitch, not a real start bit
            end else begin
              state    <= ST_DATA;
              bit_idx  <= '0;
              zero_acc <= 1'b1;
              fe_acc   <= 1'b0;
              pe_acc   <= 1'b0;
            end
          end
        end

        ST_DATA: begin
          if (decide) begin
            // Shift in at the top so the first bit ends up at bit 0.
            shreg    <= {maj, shreg[DATA_BITS-1:1]};
            zero_acc <= zero_acc & ~maj;
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              state    <= HAS_PAR ? ST_PAR : ST_STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        ST_PAR: begin
          if (decide) begin
            // XOR over data+parity is 1 for an odd count of ones.
            pe_acc   <= ((^shreg) ^ maj) != ODD_PAR;
            zero_acc <= zero_acc & ~maj;
            state    <= ST_STOP;
            stop_idx <= 1'b0;
          end
        end

        ST_STOP: begin
          if (decide) begin
            if (last_stop) begin
              hi_flag <= 1'b0;
              state   <= frm_brk ? ST_BRK_WAIT : ST_IDLE;
            end else begin
              fe_acc   <= frm_fe;
              zero_acc <= frm_brk;
              stop_idx <= 1'b1;
            end
          end
        end

        ST_BRK_WAIT: begin
          // Leave only after the line has stayed high across a whole tick.
          if (!rx_sync)  hi_flag <= 1'b0;
          else if (tick) begin
            if (hi_flag) state <= ST_IDLE;
            else         hi_flag <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase

      // Clear first; a same-cycle overrun below overrides it.
      if (i_Err_Clr) o_Overrun <= 1'b0;

      if (last_stop) begin
        if (!o_Rx_Valid || i_Rx_Ready) begin
          o_Rx_Byte    <= frm_brk ? '0 : shreg;
          o_Parity_Err <= pe_acc;
          o_Frame_Err  <= frm_fe;
          o_Break      <= frm_brk;
          o_Rx_Valid   <= 1'b1;
        end else begin
          o_Overrun <= 1'b1;           // held frame wins, new one dropped
        end
      end else if (o_Rx_Valid && i_Rx_Ready) begin
        o_Rx_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, the successor to the fixed 8N1 receive path of `uart_controller`. Adds configurable data width, parity and stop-bit count, an exact fractional baud generator, 3-sample majority voting, and a valid/ready output handshake. It also flags parity, framing, overrun and break conditions. It sits between the synchronised pad input and the byte-consuming logic, and can be instantiated standalone or inside `uart_controller`.

## Interface
- `CLOCK_RATE`, 25000000: system clock frequency, Hz.
- `BAUD_RATE`, 115200: line bit rate, bits/s.
- `RX_OVERSAMPLE`, 16: ticks per bit; even, ≥8.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits checked, 1 or 2.

Ports:
- `clk` input 1: system clock, all logic on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `i_Rx_Data` input 1: serial line, idle high, asynchronous to `clk`.
- `i_Rx_Ready` input 1: consumer accepts the held frame when high with `o_Rx_Valid`.
- `i_Err_Clr` input 1: single-cycle pulse that clears sticky `o_Overrun`.
- `o_Rx_Byte` output DATA_BITS: received data, LSB = first bit on line.
- `o_Rx_Valid` output 1: held frame available.
- `o_Parity_Err` output 1: parity mismatch for the held frame.
- `o_Frame_Err` output 1: a stop bit sampled low for the held frame.
- `o_Break` output 1: held frame is a break.
- `o_Overrun` output 1: sticky; a frame was dropped.

## Operation
- Input: 2-flop synchroniser on `i_Rx_Data`; all decisions use the synchronised value.
- Tick generator: 32-bit phase accumulator, adding `BAUD_RATE*RX_OVERSAMPLE` each clk.
  - When the sum ≥ `CLOCK_RATE`, subtract `CLOCK_RATE` and pulse `tick` for one clk.
  - Long-run tick rate is exact; no truncation drift.
- Per-bit tick counter 0..RX_OVERSAMPLE-1.
  - Samples are taken at counts M-1, M, M+1, where M = RX_OVERSAMPLE/2.
  - The bit value is the majority of the three samples, decided at M+1.
- States:
  - IDLE: on synchronised 1→0, zero the tick counter and accumulator, go to START.
  - START: a majority of 1 is a false start; return to IDLE with no output. A majority of 0 goes to DATA.
  - DATA: shift DATA_BITS bits LSB-first, then go to PARITY if PARITY≠0, else STOP.
  - PARITY: compare the sampled bit with the computed parity. Odd requires an odd count of ones over data+parity; even requires an even count.
  - STOP: sample STOP_BITS stop bits; any 0 sets the frame error. After the last stop decision, deliver the frame. Then go to IDLE, or to BREAK_WAIT if a break was detected.
  - BREAK_WAIT: stay until the synchronised line is 1 for one full tick, then IDLE.
- Break: all data bits, the parity bit (if present) and all stop bits sampled 0. Sets `o_Break`=1, `o_Frame_Err`=1 and `o_Rx_Byte`=0.
- Delivery:
  - If `o_Rx_Valid`=0, or the frame is accepted in the same clk (valid & ready): load the byte and error flags, and set valid.
  - Otherwise drop the new frame, keep the held frame unchanged and set `o_Overrun`.
- Handshake: the cycle with `o_Rx_Valid` & `i_Rx_Ready`, and no new delivery, clears valid. The byte and error flags hold their values until the next load.
- `o_Overrun` clears only on `i_Err_Clr`. If `i_Err_Clr` and a new overrun occur in the same clk, the set wins.

## Timing
- Reset: all outputs 0, state IDLE, accumulator and counters 0, synchroniser flops 1.
- Reset assertion mid-frame aborts immediately; no partial frame is delivered.
- Detection latency: 2 clk synchroniser plus 1 clk edge detect.
- `o_Rx_Valid` rises 1 clk after the tick that decides the last stop bit, about (1+DATA_BITS+P+STOP_BITS−0.5) bit periods after the start edge, where P = 1 if PARITY≠0 else 0.
- Back-to-back frames are accepted: the next start edge is detected from IDLE in the second half of the stop bit.
- Bit-rate tolerance: frames up to ±3% off nominal are received correctly at RX_OVERSAMPLE=16, 8N1.
- `i_Rx_Ready` may be held high permanently; valid then pulses one clk per frame.

## Test plan
1. Default parameters. Send 0xA5 8N1 at 8680 ns/bit, then 0x3C at +3% bit rate, with ready held high. Required: two 1-clk valid pulses with bytes A5 then 3C, all error flags 0.
2. PARITY=2. Send 0x55 with parity bit 1 (wrong). Required: byte 55, `o_Parity_Err`=1. Then send 0x55 with parity 0. Required: `o_Parity_Err`=0.
3. Send 0x3C with the stop bit driven 0. Required: byte 3C, `o_Frame_Err`=1, `o_Break`=0.
4. Ready low; send 0x11 then 0x22. Required: byte 11 held, valid=1, `o_Overrun`=1. Then raise ready. Required: valid clears, byte stays 11. Then pulse `i_Err_Clr`. Required: `o_Overrun`=0.
5. Drive a 2 µs low glitch. Required: no valid, state IDLE. Then assert reset mid-frame on 0x81. Required: no valid, all outputs 0. Then send 0x81. Required: byte 81.
6. Hold the line low for 20 bit periods, then high, then send 0x7E. Required: exactly one valid with byte 00, `o_Break`=1, `o_Frame_Err`=1; then a valid with byte 7E and no errors.
